poly1305_reduce_arbiter: RTL and testbench
==========================================

Name: poly1305_reduce_arbiter

Overview:
Shares one poly1305 modular-reduction unit (258-bit in, 130-bit out, start/busy/done interface) between NUM_REQ independent requesters, e.g. the accumulator multiply path and the tag-finalisation path.
- Round-robin arbitration, one job in flight at a time.
- Sequences the reducer's start/done handshake and returns each result to the requester that issued it.
- Watchdog flags a reducer that never asserts done.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
TIMEOUT_CYCLES, 16, maximum cycles in WAIT before a timeout is declared (≥4).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  NUM_REQ  requester i has a value pending.
req_value  in  NUM_REQ*258  flattened operands; requester i occupies bits [258*i+257 : 258*i].
req_ready  out  NUM_REQ  one-hot; operand of requester i accepted this cycle.
resp_valid  out  NUM_REQ  one-hot; result for requester i available.
resp_ready  in  NUM_REQ  requester i consumes its result.
resp_value  out  130  result, valid while any resp_valid bit is set.
resp_error  out  1  qualifies resp_value; 1 means the job timed out and resp_value is 0.
red_start  out  1  single-cycle start pulse to the reducer.
red_value_in  out  258  operand to the reducer, held stable from ISSUE until done.
red_busy  in  1  reducer busy; arbiter does not issue while it is high.
red_done  in  1  single-cycle completion pulse from the reducer.
red_value_out  in  130  reducer result, sampled in the cycle red_done=1.

Behaviour:
- Reset values (asynchronous): state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_value=0, resp_error=0, red_start=0, red_value_in=0, timer=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid and red_busy=0, grant the first valid index searching from rr_ptr upward with wrap-around.
  - Grant cycle: req_ready[g]=1 for exactly one cycle, latch req_value slice g into red_value_in, record g.
  - Go to ISSUE.
  - If red_busy=1, stay in IDLE; no req_ready is asserted.
- ISSUE: red_start=1 for exactly one cycle; timer cleared; go to WAIT.
- WAIT: timer increments each cycle.
  - red_done=1: latch red_value_out into resp_value, resp_error=0, go to RESP.
  - timer reaches TIMEOUT_CYCLES-1 without red_done: resp_value=0, resp_error=1, go to RESP.
  - red_done and the timeout in the same cycle: done wins.
- RESP: resp_valid[g]=1, held with resp_value and resp_error stable until resp_ready[g]=1.
  - Handshake cycle: resp_valid drops next cycle; rr_ptr=(g+1) mod NUM_REQ; go to IDLE.
  - resp_ready on other indices is ignored.
- req_valid deasserting after the grant does not affect the job in flight.
- A red_done pulse outside WAIT is ignored.
- Throughput: best case 1 (IDLE) + 1 (ISSUE) + reducer latency + 1 (RESP with resp_ready already high) cycles per job. No back-to-back overlap.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.
- Reset asserted mid-operation: every output returns to its reset value immediately; the job is dropped with no response. Requesters must re-issue.
- Width rule: red_value_in carries the full 258 bits unmodified; resp_value is exactly red_value_out.

Optional Feature:
Macro POLY_ARB_STATS_EN.
- Defined: adds output ports stat_jobs[15:0] and stat_timeouts[7:0].
  - stat_jobs increments on every RESP handshake.
  - stat_timeouts increments on every handshake with resp_error=1.
  - Both saturate at all-ones; both reset to 0.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Single job: req_valid=01, req_value[0]=2^130 (lo=0, hi=1); reducer model returns 5 after 2 cycles -> red_start one pulse; resp_valid=01, resp_value=5, resp_error=0.
- Contention: req_valid=11 held, values 7 and (1<<130)+3; reducer model returns lo+5*hi -> grants in order 0,1,0,1; responses 7 then 8, each to the correct one-hot resp_valid.
- Backpressure: resp_ready=0 for 10 cycles while in RESP -> resp_valid and resp_value stable for 10 cycles, no new req_ready; resp_ready=1 -> next grant to the other requester.
- Timeout: reducer model never asserts done -> exactly TIMEOUT_CYCLES (16) cycles after red_start, resp_error=1 and resp_value=0; with POLY_ARB_STATS_EN, stat_timeouts goes 0 -> 1 after the handshake.
- Busy gating: red_busy=1 while req_valid=01 -> no req_ready and no red_start until red_busy=0.
- Reset mid-WAIT: assert reset 3 cycles after red_start -> all outputs 0 immediately; after release, req_valid=10 is granted first because rr_ptr=0 and requester 0 is not valid.

Source files
------------

// File: rtl/poly1305_reduce_arbiter_if.sv
// Bundles the requester-side and reducer-side signals of poly1305_reduce_arbiter.
// slave = arbiter view, master = environment (requesters plus reducer).
interface poly1305_reduce_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*258-1:0] req_value;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ-1:0]     resp_valid;
    logic [NUM_REQ-1:0]     resp_ready;
    logic [129:0]           resp_value;
    logic                   resp_error;
    logic                   red_start;
    logic [257:0]           red_value_in;
    logic                   red_busy;
    logic                   red_done;
    logic [129:0]           red_value_out;

    modport slave (
        input  req_valid, req_value, resp_ready, red_busy, red_done, red_value_out,
        output req_ready, resp_valid, resp_value, resp_error, red_start, red_value_in
    );

    modport master (
        output req_valid, req_value, resp_ready, red_busy, red_done, red_value_out,
        input  req_ready, resp_valid, resp_value, resp_error, red_start, red_value_in
    );
endinterface

// File: rtl/poly1305_reduce_arbiter.sv
// Round-robin sharing of one poly1305 reduction unit between NUM_REQ requesters,
// with a done watchdog. Define POLY_ARB_STATS_EN to add job/timeout counters.
module poly1305_reduce_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    poly1305_reduce_arbiter_if.slave  bus,
    output logic [1:0]                dbg_state
`ifdef POLY_ARB_STATS_EN
    ,
    output logic [15:0]               stat_jobs,
    output logic [7:0]                stat_timeouts
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic [TMR_W-1:0] timer;
    logic [257:0]     op_q;
    logic [129:0]     res_q;
    logic             err_q;
    logic             grant;
    logic             resp_hs;
    logic             timeout_hit;

    // First valid requester at or after rr_ptr; scanning offsets downward lets
    // the smallest offset overwrite the others.
    always_comb begin : pick
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (bus.req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(idx);
            end
        end
    end

    // Handshakes: a requester operand transfers in the cycle req_valid[i] and
    // req_ready[i] are both high; a result transfers in the cycle resp_valid[i]
    // and resp_ready[i] are both high. Neither valid may depend on its ready.
    assign grant       = (state == S_IDLE) && pick_found && !bus.red_busy;
    assign resp_hs     = (state == S_RESP) && bus.resp_ready[gnt_idx];
    assign timeout_hit = (timer == TMR_W'(TIMEOUT_CYCLES - 1));

    assign bus.req_ready    = (grant && !reset) ? (NUM_REQ'(1) << pick_idx) : '0;
    assign bus.red_start    = (state == S_ISSUE);
    assign bus.resp_valid   = (state == S_RESP) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign bus.resp_value   = res_q;
    assign bus.resp_error   = err_q;
    assign bus.red_value_in = op_q;
    assign dbg_state        = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            rr_ptr  <= '0;
            gnt_idx <= '0;
            timer   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        op_q    <= bus.req_value[258*pick_idx +: 258];
                        gnt_idx <= pick_idx;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving together with the timeout still counts as done.
                    if (bus.red_done) begin
                        res_q <= bus.red_value_out;
                        err_q <= 1'b0;
                        state <= S_RESP;
                    end else if (timeout_hit) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_hs) begin
                        rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef POLY_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_jobs     <= '0;
            stat_timeouts <= '0;
        end else if (resp_hs) begin
            if (stat_jobs != '1) stat_jobs <= stat_jobs + 1'b1;
            if (err_q && stat_timeouts != '1) stat_timeouts <= stat_timeouts + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_poly1305_reduce_arbiter.sv
// Directed scoreboard bench for poly1305_reduce_arbiter with a lo+5*hi reducer model.
module tb_poly1305_reduce_arbiter;
  localparam int NUM_REQ = 2;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int W = 133;  // {idx[1:0], value[129:0], error}

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] dbg_state;
  logic [257:0] op0, op1;
  logic hang = 1'b0;
  int start_cnt = 0;
  int model_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  logic [NUM_REQ-1:0] exp_gnt_q[$];
  logic [257:0] exp_op_q[$];

  poly1305_reduce_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef POLY_ARB_STATS_EN
  logic [15:0] stat_jobs;
  logic [7:0] stat_timeouts;
`endif

  poly1305_reduce_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state(dbg_state)
`ifdef POLY_ARB_STATS_EN
    ,
    .stat_jobs(stat_jobs),
    .stat_timeouts(stat_timeouts)
`endif
  );

  assign bus.req_value = {op1, op0};

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [259:0] act, input logic [259:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  function automatic logic [W-1:0] mk(input int idx, input logic [129:0] val, input logic err);
    logic [1:0] i2;
    i2 = idx[1:0];
    return {i2, val, err};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_job(input int idx, input logic [257:0] op, input logic [129:0] val,
                            input logic err);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    exp_gnt_q.push_back(oh);
    exp_op_q.push_back(op);
    exp_q.push_back(mk(idx, val, err));
  endtask

  task automatic wait_gnt_done(input string name, input int budget);
    int n;
    n = 0;
    while (exp_gnt_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_gnt_q.size() != 0) fail_now(name);
  endtask

  task automatic wait_resp_done(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) fail_now(name);
  endtask

  // reducer model: result = lo + 5*hi, done two cycles after start
  always @(negedge clk) begin
    if (reset) begin
      model_cnt = 0;
      bus.red_done = 1'b0;
    end else begin
      bus.red_done = 1'b0;
      if (bus.red_start) begin
        start_cnt++;
        if (exp_op_q.size() == 0) fail_now("red_value_in_unexpected");
        else chk("red_value_in", bus.red_value_in, exp_op_q.pop_front());
        model_cnt = hang ? 0 : 2;
        bus.red_value_out = bus.red_value_in[129:0] + 130'(5) * 130'(bus.red_value_in[257:130]);
      end else if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0) bus.red_done = 1'b1;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [NUM_REQ-1:0] oh;
    if (!reset) begin
      if (bus.req_ready != '0) begin
        if (exp_gnt_q.size() == 0) fail_now("unexpected_grant");
        else chk("grant", bus.req_ready, exp_gnt_q.pop_front());
      end
      if (bus.resp_valid != '0) begin
        if (exp_q.size() == 0) fail_now("unexpected_resp");
        else begin
          e = exp_q[0];
          oh = '0;
          oh[e[W-1:W-2]] = 1'b1;
          chk("resp_valid", bus.resp_valid, oh);
          chk("resp_value", bus.resp_value, e[130:1]);
          chk("resp_error", bus.resp_error, e[0]);
          if ((bus.resp_valid & bus.resp_ready) != '0) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_resp_valid"}, bus.resp_valid, 0);
    chk({tag, "_resp_value"}, bus.resp_value, 0);
    chk({tag, "_resp_error"}, bus.resp_error, 0);
    chk({tag, "_red_start"}, bus.red_start, 0);
    chk({tag, "_red_value_in"}, bus.red_value_in, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int n;
    int s0;
    bus.req_valid = '0;
    bus.resp_ready = 2'b11;
    bus.red_busy = 1'b0;
    bus.red_done = 1'b0;
    bus.red_value_out = '0;
    op0 = '0;
    op1 = '0;

    // reset state, with a request already pending
    bus.req_valid = 2'b01;
    repeat (3) tick();
    check_all_zero("reset");
    bus.req_valid = '0;
    reset = 1'b0;
    tick();

    // single job: 2^130 -> 5
    op0 = 258'(1) << 130;
    s0 = start_cnt;
    expect_job(0, op0, 130'd5, 1'b0);
    bus.req_valid = 2'b01;
    wait_gnt_done("single_grant", 20);
    bus.req_valid = '0;
    wait_resp_done("single_resp", 40);
    chk("single_start_pulses", start_cnt - s0, 1);

    // contention from a fresh rr_ptr
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    op0 = 258'd7;
    op1 = (258'(1) << 130) + 258'd3;
    expect_job(0, op0, 130'd7, 1'b0);
    expect_job(1, op1, 130'd8, 1'b0);
    expect_job(0, op0, 130'd7, 1'b0);
    expect_job(1, op1, 130'd8, 1'b0);
    bus.req_valid = 2'b11;
    wait_gnt_done("contention_grants", 80);
    bus.req_valid = '0;
    wait_resp_done("contention_resp", 40);

    // backpressure
    bus.resp_ready = 2'b00;
    expect_job(0, op0, 130'd7, 1'b0);
    bus.req_valid = 2'b11;
    n = 0;
    while (bus.resp_valid == '0 && n < 30) begin
      tick();
      n++;
    end
    if (bus.resp_valid == '0) fail_now("backpressure_resp");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_resp_valid_held", bus.resp_valid, 2'b01);
    end
    expect_job(1, op1, 130'd8, 1'b0);
    bus.resp_ready = 2'b11;
    wait_gnt_done("bp_next_grant", 20);
    bus.req_valid = '0;
    wait_resp_done("bp_resp", 40);

    // timeout
`ifdef POLY_ARB_STATS_EN
    chk("stat_timeouts_before", stat_timeouts, 0);
`endif
    hang = 1'b1;
    op0 = 258'd11;
    expect_job(0, op0, 130'd0, 1'b1);
    bus.req_valid = 2'b01;
    n = 0;
    while (!bus.red_start && n < 20) begin
      tick();
      n++;
    end
    bus.req_valid = '0;
    if (!bus.red_start) fail_now("timeout_start");
    n = 0;
    while (n < 40) begin
      tick();
      if (bus.resp_valid != '0) break;
      n++;
    end
    chk("timeout_latency", n, TIMEOUT_CYCLES);
    wait_resp_done("timeout_resp", 20);
    tick();
`ifdef POLY_ARB_STATS_EN
    chk("stat_timeouts_after", stat_timeouts, 1);
    chk("stat_jobs", stat_jobs, 7);
`endif
    hang = 1'b0;

    // busy gating
    bus.red_busy = 1'b1;
    op0 = 258'(1) << 130;
    s0 = start_cnt;
    bus.req_valid = 2'b01;
    repeat (6) tick();
    chk("busy_no_start", start_cnt - s0, 0);
    expect_job(0, op0, 130'd5, 1'b0);
    bus.red_busy = 1'b0;
    wait_gnt_done("busy_release_grant", 10);
    bus.req_valid = '0;
    wait_resp_done("busy_resp", 40);

    // reset in the middle of WAIT
    hang = 1'b1;
    op0 = (258'(1) << 130) | 258'd9;
    s0 = start_cnt;
    exp_gnt_q.push_back(2'b01);
    exp_op_q.push_back(op0);
    bus.req_valid = 2'b01;
    n = 0;
    while (start_cnt == s0 && n < 20) begin
      tick();
      n++;
    end
    bus.req_valid = '0;
    if (start_cnt == s0) fail_now("midwait_start");
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check_all_zero("midwait_reset");
    tick();
    reset = 1'b0;
    hang = 1'b0;
    op1 = (258'(1) << 130) + 258'd3;
    expect_job(1, op1, 130'd8, 1'b0);
    bus.req_valid = 2'b10;
    wait_gnt_done("post_reset_grant", 10);
    bus.req_valid = '0;
    wait_resp_done("post_reset_resp", 40);

    repeat (3) tick();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp_op_q_drained", exp_op_q.size(), 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
